// File: rtl/spi_master.sv
// SPI master with programmable mode, bit order and slave-select hold.
// Ports:
//   clk, rst_n             - system clock, async active-low reset
//   cs, rd, wr             - host strobes; wr starts a transfer, rd clears rx_valid
//   din, ss_sel            - transmit word and target slave index
//   cpol, cpha, lsb_first,
//   hold                   - mode controls, captured when a transfer starts
//   dout, rx_valid         - last received word and its unread flag
//   busy, done             - transfer in progress / one-cycle completion pulse
//   miso, mosi, sclk, ss_n - SPI bus (ss_n active low, one line per slave)
module spi_master #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned NCS    = 4,
  parameter int unsigned CLKDIV = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [DWIDTH-1:0]        din,
  input  logic [$clog2(NCS)-1:0]   ss_sel,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic                     lsb_first,
  input  logic                     hold,
  output logic [DWIDTH-1:0]        dout,
  output logic                     busy,
  output logic                     done,
  output logic                     rx_valid,
  input  logic                     miso,
  output logic                     mosi,
  output logic                     sclk,
  output logic [NCS-1:0]           ss_n
);

  localparam int unsigned SW = $clog2(NCS);
  localparam int unsigned TW = $clog2(CLKDIV);
  localparam int unsigned CW = $clog2(2 * DWIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_LAG} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DWIDTH-1:0]   tx_q, tx_d;
  logic [DWIDTH-1:0]   rx_q, rx_d;
  logic [DWIDTH-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rxv_q, rxv_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic [NCS-1:0]      ss_n_q, ss_n_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                hold_q, hold_d;

  logic                start;
  logic                tick;
  logic                odd_tgl;
  logic                first_tgl;
  logic                last_tgl;
  logic                do_sample;
  logic                do_shift;
  logic [NCS-1:0]      sel_n;
  logic [DWIDTH-1:0]   tx_shift;
  logic [DWIDTH-1:0]   rx_shift;

  assign start     = cs & wr & ~rd & ~busy_q;
  assign tick      = (timer_q == '0);
  // cnt_q holds toggles already made, so the upcoming toggle is cnt_q+1
  assign odd_tgl   = ~cnt_q[0];
  assign first_tgl = (cnt_q == '0);
  assign last_tgl  = (cnt_q == CW'(2 * DWIDTH - 1));
  // First bit is already on mosi from start, so the leading shift of CPHA=1 is skipped
  assign do_sample = cpha_q ? ~odd_tgl : odd_tgl;
  assign do_shift  = cpha_q ? (odd_tgl & ~first_tgl) : (~odd_tgl & ~last_tgl);
  assign tx_shift  = lsb_q ? {1'b0, tx_q[DWIDTH-1:1]} : {tx_q[DWIDTH-2:0], 1'b0};
  assign rx_shift  = lsb_q ? {miso, rx_q[DWIDTH-1:1]} : {rx_q[DWIDTH-2:0], miso};

  // Active-low decode of ss_sel; out-of-range indices select nothing
  always_comb begin
    sel_n = '1;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (ss_sel == SW'(i)) sel_n[i] = 1'b0;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rxv_d   = rxv_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    ss_n_d  = ss_n_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    hold_d  = hold_q;

    if (cs & rd & ~wr) rxv_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        if (start) begin
          state_d = S_SETUP;
          timer_d = TW'(CLKDIV - 1);
          cnt_d   = '0;
          tx_d    = din;
          rx_d    = '0;
          busy_d  = 1'b1;
          ss_n_d  = sel_n;
          mosi_d  = lsb_first ? din[0] : din[DWIDTH-1];
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          hold_d  = hold;
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_XFER;
          timer_d = TW'(CLKDIV - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_XFER: begin
        if (tick) begin
          timer_d = TW'(CLKDIV - 1);
          sclk_d  = ~sclk_q;
          cnt_d   = cnt_q + CW'(1);
          if (do_sample) rx_d = rx_shift;
          if (do_shift) begin
            tx_d   = tx_shift;
            mosi_d = lsb_q ? tx_shift[0] : tx_shift[DWIDTH-1];
          end
          if (last_tgl) state_d = S_LAG;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_LAG: begin
        if (tick) begin
          state_d = S_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          dout_d  = rx_q;
          rxv_d   = 1'b1;
          if (!hold_q) ss_n_d = '1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rxv_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ss_n_q  <= '1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rxv_q   <= rxv_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      hold_q  <= hold_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_valid = rxv_q;
  assign mosi     = mosi_q;
  assign sclk     = sclk_q;
  assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DWIDTH=8, NCS=4, CLKDIV=4).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs, rd, wr;
  logic [7:0] din;
  logic [1:0] ss_sel;
  logic       cpol, cpha, lsb_first, hold;
  logic [7:0] dout;
  logic       busy, done, rx_valid;
  logic       miso, mosi, sclk;
  logic [3:0] ss_n;
  logic       loop_en;
  logic       s_miso;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_idle_ssn;

  typedef struct {
    logic       cpol, cpha, lsb, hold, loop;
    logic [1:0] ss_sel;
    logic [7:0] din, sword, exp_dout, exp_cap;
  } vec_t;

  vec_t vecs[7];

  spi_master #(.DWIDTH(8), .NCS(4), .CLKDIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .din(din),
    .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .hold(hold), .dout(dout), .busy(busy), .done(done), .rx_valid(rx_valid),
    .miso(miso), .mosi(mosi), .sclk(sclk), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : s_miso;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transfer with a slave model; optional stray wr / rd strobes at given edges
  task automatic run_xfer(input vec_t v, input int wr_at, input int rd_at);
    logic [3:0] sel_n;
    logic       prev_sclk, lead, ssn_ok;
    int         s_idx, done_cnt, done_cyc;
    logic [7:0] cap, d_dout;
    logic       d_rxv, d_busy, d_sclk, rxv_after;
    logic [3:0] d_ssn;
    sel_n = ~(4'b0001 << v.ss_sel);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b0;
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; hold = v.hold;
    din = v.din; ss_sel = v.ss_sel; loop_en = v.loop;
    s_idx  = v.cpha ? 0 : 1;
    s_miso = v.cpha ? 1'b0 : v.sword[7];
    @(posedge clk); #1;
    chk("rx_valid_cleared", 32'(rx_valid), 32'(0));
    chk("sclk_idle", 32'(sclk), 32'(v.cpol));
    chk("ss_n_idle", 32'(ss_n), 32'(exp_idle_ssn));
    rd = 1'b0;
    @(negedge clk);
    wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    chk("busy_at_start", 32'(busy), 32'(1));
    prev_sclk = sclk;
    ssn_ok = 1'b1; done_cnt = 0; done_cyc = -1; cap = '0; rxv_after = 1'bx;
    d_dout = 'x; d_rxv = 1'bx; d_busy = 1'bx; d_sclk = 1'bx; d_ssn = 'x;
    for (int n = 1; n <= 200; n++) begin
      if (n == wr_at) begin wr = 1'b1; din = ~v.din; end
      else wr = 1'b0;
      rd = (rd_at != 0) && (n == rd_at || n == rd_at + 1);
      @(posedge clk); #1;
      if (busy && ss_n !== sel_n) ssn_ok = 1'b0;
      if (sclk !== prev_sclk) begin
        lead = (sclk != v.cpol);
        if (lead == v.cpha) begin
          if (s_idx < 8) begin s_miso = v.sword[7 - s_idx]; s_idx++; end
        end else begin
          cap = {cap[6:0], mosi};
        end
        prev_sclk = sclk;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = n;
          d_dout = dout; d_rxv = rx_valid; d_busy = busy; d_sclk = sclk; d_ssn = ss_n;
        end
      end
      if (done_cyc >= 0 && n == done_cyc + 1) begin
        rxv_after = rx_valid;
        break;
      end
    end
    wr = 1'b0; rd = 1'b0; din = v.din;
    chk("done_cycle", 32'(done_cyc), 32'(72));
    chk("done_count", 32'(done_cnt), 32'(1));
    chk("dout", 32'(d_dout), 32'(v.exp_dout));
    chk("rx_valid_at_done", 32'(d_rxv), 32'(1));
    chk("busy_at_done", 32'(d_busy), 32'(0));
    chk("sclk_after", 32'(d_sclk), 32'(v.cpol));
    chk("ss_n_after", 32'(d_ssn), 32'(v.hold ? sel_n : 4'hF));
    chk("ss_n_during", 32'(ssn_ok), 32'(1));
    chk("mosi_capture", 32'(cap), 32'(v.exp_cap));
    chk("rx_valid_next", 32'(rxv_after), 32'((rd_at != 0) ? 0 : 1));
    exp_idle_ssn = v.hold ? sel_n : 4'hF;
  endtask

  initial begin
    vec_t tmp;
    //          cpol cpha lsb hold loop ss   din    sword  dout   mosi-cap
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'hA5, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h3C, 8'h96, 8'h69, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'h12, 8'h0F, 8'hF0, 8'h48};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h6B, 8'h00, 8'h6B, 8'hD6};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h77, 8'h3A, 8'h3A, 8'h77};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'h0E, 8'hE1, 8'hE1, 8'h0E};

    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; din = '0; ss_sel = '0;
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; hold = 1'b0;
    loop_en = 1'b0; s_miso = 1'b0; exp_idle_ssn = 4'hF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_sclk", 32'(sclk), 32'(0));
    chk("rst_mosi", 32'(mosi), 32'(0));
    chk("rst_ss_n", 32'(ss_n), 32'(4'hF));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_xfer(vecs[i], 0, 0);

    // Stray write mid-transfer must be ignored
    tmp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h3E, 8'h00, 8'h3E, 8'h3E};
    run_xfer(tmp, 10, 0);

    // rd on the completion edge loses; rd one edge later clears
    tmp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'hC6, 8'h2D, 8'h2D, 8'hC6};
    run_xfer(tmp, 0, 72);

    // rd & wr together, and wr without cs, must not start
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    chk("rdwr_no_start", 32'(busy), 32'(0));
    cs = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    chk("nocs_no_start", 32'(busy), 32'(0));
    wr = 1'b0;

    // Leave rx_valid set, then reset in the middle of XFER
    run_xfer(vecs[0], 0, 0);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; hold = 1'b1;
    din = 8'hF0; ss_sel = 2'd1; loop_en = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'(1));
    chk("mid_ss_n", 32'(ss_n), 32'(4'hD));
    rst_n = 1'b0;
    #1;
    chk("arst_ss_n", 32'(ss_n), 32'(4'hF));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_sclk", 32'(sclk), 32'(0));
    chk("arst_rx_valid", 32'(rx_valid), 32'(0));
    chk("arst_dout", 32'(dout), 32'(0));
    begin
      int seen = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (80) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      chk("no_done_after_reset", 32'(seen), 32'(0));
      chk("idle_after_reset", 32'(busy), 32'(0));
    end
    exp_idle_ssn = 4'hF;
    run_xfer(vecs[1], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
